uart_byte_tx: RTL and testbench

Serial transmitter for the USART link: accepts one byte over a single-cycle request, serialises it as 8N1 (start, 8 data bits LSB first, stop) at a selectable baud rate, and signals completion. It drives the line that the team's USART receiver samples. Both blocks share the same `Baud_set` encoding and clock frequency.

---
 rtl/uart_byte_tx.sv | 148 ++++++++++++++
 tb/tb_uart_byte_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serial transmitter with selectable baud rate.
// A byte is accepted with a single-cycle Send_en pulse while idle. It is sent
// as a start bit, eight data bits LSB first, and a stop bit. The serial line
// and the status flags are flop outputs, so the line cannot glitch inside a bit.
module uart_byte_tx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Baud_set,
    input  logic [7:0] Data,
    input  logic       Send_en,
    output logic       usart_tx,
    output logic       Tx_busy,
    output logic       Tx_Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bit periods in clock cycles. The divider runs 0..N-1, so the terminal count is N-1.
    localparam int unsigned N_9600   = CLK_FREQ_HZ / 32'd9600;
    localparam int unsigned N_19200  = CLK_FREQ_HZ / 32'd19200;
    localparam int unsigned N_38400  = CLK_FREQ_HZ / 32'd38400;
    localparam int unsigned N_57600  = CLK_FREQ_HZ / 32'd57600;
    localparam int unsigned N_115200 = CLK_FREQ_HZ / 32'd115200;

    localparam logic [12:0] TC_9600   = 13'(N_9600   - 32'd1);
    localparam logic [12:0] TC_19200  = 13'(N_19200  - 32'd1);
    localparam logic [12:0] TC_38400  = 13'(N_38400  - 32'd1);
    localparam logic [12:0] TC_57600  = 13'(N_57600  - 32'd1);
    localparam logic [12:0] TC_115200 = 13'(N_115200 - 32'd1);

    // Maps a rate select code to its divider terminal count; unused codes fall back to 9600.
    function automatic logic [12:0] baud_tc(input logic [2:0] sel);
        logic [12:0] tc;
        case (sel)
            3'd0:    tc = TC_9600;
            3'd1:    tc = TC_19200;
            3'd2:    tc = TC_38400;
            3'd3:    tc = TC_57600;
            3'd4:    tc = TC_115200;
            default: tc = TC_9600;
        endcase
        return tc;
    endfunction

    state_t      state_q;
    logic [12:0] div_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [2:0]  baud_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        div_last_s;

    // Flag the last cycle of the current bit, using the rate latched at acceptance.
    always_comb begin
        div_last_s = 1'b0;
        if (div_cnt_q == baud_tc(baud_q)) begin
            div_last_s = 1'b1;
        end else begin
            div_last_s = 1'b0;
        end
    end

    // Frame sequencer: owns the divider, bit counter, shift register and all outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            div_cnt_q <= 13'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            baud_q    <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_cnt_q <= 13'd0;
                    if (Send_en) begin
                        shift_q <= Data;
                        baud_q  <= Baud_set;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (div_last_s) begin
                        div_cnt_q <= 13'd0;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        div_cnt_q <= div_cnt_q + 13'd1;
                    end
                end
                DATA: begin
                    if (div_last_s) begin
                        div_cnt_q <= 13'd0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[bit_cnt_q + 3'd1];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 13'd1;
                    end
                end
                STOP: begin
                    if (div_last_s) begin
                        div_cnt_q <= 13'd0;
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 13'd1;
                    end
                end
                default: begin
                    div_cnt_q <= 13'd0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign usart_tx = tx_q;
    assign Tx_busy  = busy_q;
    assign Tx_Done  = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx. The stimulus side predicts each accepted frame
// from the transmitter's rules (acceptance only when idle, bit period from the
// baud table) and queues it. A monitor watching the line checks every cycle of
// each frame, the Tx_Done pulse, and the idle and reset behaviour.
module tb_uart_byte_tx;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef struct {
        logic [7:0] d;
        int         n;
        int         a;
    } exp_t;

    logic       Clk;
    logic       Reset;
    logic [2:0] Baud_set;
    logic [7:0] Data;
    logic       Send_en;
    logic       usart_tx;
    logic       Tx_busy;
    logic       Tx_Done;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   free_at = 0;
    int   last_a = 0;
    int   exp_done = 0;
    int   done_seen = 0;
    logic rst_at_edge = 1'b0;
    exp_t exp_q[$];

    // Monitor state.
    bit   in_frame = 1'b0;
    exp_t cur;
    int   off;
    int   b;
    logic lvl;

    uart_byte_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Baud_set (Baud_set),
        .Data     (Data),
        .Send_en  (Send_en),
        .usart_tx (usart_tx),
        .Tx_busy  (Tx_busy),
        .Tx_Done  (Tx_Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle counter: the value seen at a falling edge names the cycle after that rising edge.
    always @(posedge Clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= Reset;
    end

    // Bit period in cycles for a rate select code, straight from the baud table.
    function automatic int n_of(input logic [2:0] bs);
        int rate;
        case (bs)
            3'd0:    rate = 9600;
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return CLK_HZ / rate;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Present a request for one cycle; the model accepts it only if the line is free.
    task automatic send(input logic [7:0] d, input logic [2:0] bs);
        int n;
        Data     = d;
        Baud_set = bs;
        Send_en  = 1'b1;
        if (cyc >= free_at) begin
            n      = n_of(bs);
            last_a = cyc + 1;
            exp_q.push_back('{d, n, last_a});
            free_at = last_a + 10 * n;
            exp_done++;
        end
        @(negedge Clk);
        Send_en = 1'b0;
        Data    = 8'($urandom);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    // Line monitor: pairs each observed start bit with the oldest predicted frame.
    always @(negedge Clk) begin
        if (rst_at_edge) begin
            chk("reset_tx", usart_tx, 32'd1);
            chk("reset_busy", Tx_busy, 32'd0);
            chk("reset_done", Tx_Done, 32'd0);
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (Tx_Done === 1'b1) done_seen++;
            if (!in_frame) begin
                if (usart_tx === 1'b0) begin
                    chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        chk("start_cycle", cyc, cur.a);
                        in_frame = 1'b1;
                    end
                end else begin
                    chk("idle_tx", usart_tx, 32'd1);
                    chk("idle_busy", Tx_busy, 32'd0);
                    chk("idle_done", Tx_Done, 32'd0);
                end
            end
            if (in_frame) begin
                off = cyc - cur.a;
                if (off < 0) off = 0;
                if (off < 10 * cur.n) begin
                    b = off / cur.n;
                    if (b == 0) lvl = 1'b0;
                    else if (b == 9) lvl = 1'b1;
                    else lvl = cur.d[b - 1];
                    chk($sformatf("line_bit%0d_data%02h", b, cur.d), usart_tx, lvl);
                    chk("frame_busy", Tx_busy, 32'd1);
                    chk("frame_done", Tx_Done, 32'd0);
                end else begin
                    chk("end_done", Tx_Done, 32'd1);
                    chk("end_busy", Tx_busy, 32'd0);
                    chk("end_tx", usart_tx, 32'd1);
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a_keep;
        int r;
        Reset    = 1'b1;
        Send_en  = 1'b0;
        Data     = 8'd0;
        Baud_set = 3'd0;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        repeat (100) @(negedge Clk);

        // Single frame at 115200.
        send(8'hA5, 3'd4);
        wait_cyc(free_at + 3);

        // Latching: inputs change two cycles after acceptance.
        repeat ($urandom_range(1, 20)) @(negedge Clk);
        send(8'h3C, 3'd0);
        wait_cyc(last_a + 1);
        Data     = 8'hFF;
        Baud_set = 3'd4;
        wait_cyc(free_at + 2);

        // Busy rejection at 57600.
        send(8'h55, 3'd3);
        a_keep = last_a;
        wait_cyc(a_keep + $urandom_range(n_of(3'd3), 9 * n_of(3'd3)));
        send(8'h00, 3'd3);
        wait_cyc(free_at + 2);

        // Back-to-back: second request in the Tx_Done cycle.
        send(8'hF0, 3'd4);
        wait_cyc(free_at);
        send(8'h0F, 3'd4);
        wait_cyc(free_at + 2);

        // Reset during data bit 3, then a clean frame.
        send(8'h81, 3'd4);
        r = last_a + 4 * n_of(3'd4) + $urandom_range(0, n_of(3'd4) - 1);
        wait_cyc(r);
        Reset = 1'b1;
        if (cyc < free_at) exp_done--;
        free_at = 0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge Clk);
        send(8'h7E, 3'd4);
        wait_cyc(free_at + 2);

        // One frame with random data.
        send(8'($urandom), 3'd4);
        wait_cyc(free_at + 3);

        chk("monitor_idle_at_end", 32'(in_frame), 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_pulse_count", done_seen, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
